// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state encoding and step-mode type for the multiply/divide unit.
package muldiv_unit_pkg;

   localparam logic [2:0] MDU_OP_NONE  = 3'd0;
   localparam logic [2:0] MDU_OP_MULT  = 3'd1;
   localparam logic [2:0] MDU_OP_MULTU = 3'd2;
   localparam logic [2:0] MDU_OP_DIV   = 3'd3;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      MDU_ST_IDLE = 2'd0,
      MDU_ST_MUL  = 2'd1,
      MDU_ST_DIV  = 2'd2,
      MDU_ST_FIX  = 2'd3
   } mdu_state_e;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_e;

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a restoring divide step.
module muldiv_step
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  step_mode_e         mode,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      sum      = '0;
      rem_sh   = '0;
      diff     = '0;
      acc_next = acc;
      if (mode == STEP_MUL) begin
         // low half holds the unconsumed multiplier bits; the carry shifts in at the top
         sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
         acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
         // diff[WIDTH] is the borrow: set means the trial subtraction must be restored
         rem_sh = acc[2*WIDTH-1:WIDTH-1];
         diff   = rem_sh - {1'b0, operand};
         if (!diff[WIDTH]) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers; one result bit per cycle.
//  state | meaning
//  IDLE  | waiting for start; MTHI/MTLO write here
//  MUL   | shift-add iterations, counter counts down to 1
//  DIV   | restoring-division iterations, counter counts down to 1
//  FIX   | apply result signs, write HI/LO
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      counter_q;
   logic [2*WIDTH-1:0] acc_q, acc_next, prod_fix;
   logic [WIDTH-1:0]   operand_q, hi_q, lo_q;
   logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
   logic               is_mul_q, neg_lo_q, neg_hi_q, done_q;
   logic               a_neg, b_neg, op_mul, op_div, b_zero, issue;
   logic               step_en, hilo_we, mthi_we, mtlo_we;
   step_mode_e         step_mode;

   always_comb begin
      op_mul = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
      op_div = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
      b_zero = (b == '0);
      a_neg  = is_signed_op(op) & a[WIDTH-1];
      b_neg  = is_signed_op(op) & b[WIDTH-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      issue  = (state_q == MDU_ST_IDLE) && start && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= MDU_ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = MDU_ST_IDLE;
      end else begin
         case (state_q)
            MDU_ST_IDLE: begin
               if (start) begin
                  if (op_mul)      state_d = MDU_ST_MUL;
                  else if (op_div) state_d = b_zero ? MDU_ST_FIX : MDU_ST_DIV;
               end
            end
            MDU_ST_MUL: if (counter_q == CW'(1)) state_d = MDU_ST_FIX;
            MDU_ST_DIV: if (counter_q == CW'(1)) state_d = MDU_ST_FIX;
            MDU_ST_FIX: state_d = MDU_ST_IDLE;
            default:    state_d = MDU_ST_IDLE;
         endcase
      end
   end

   always_comb begin
      step_en   = !flush && ((state_q == MDU_ST_MUL) || (state_q == MDU_ST_DIV));
      hilo_we   = !flush && (state_q == MDU_ST_FIX);
      mthi_we   = issue && (op == MDU_OP_MTHI);
      mtlo_we   = issue && (op == MDU_OP_MTLO);
      step_mode = is_mul_q ? STEP_MUL : STEP_DIV;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc_q),
      .operand  (operand_q),
      .mode     (step_mode),
      .acc_next (acc_next)
   );

   // product is negated as one 2*WIDTH value; quotient and remainder carry separate signs
   always_comb begin
      prod_fix = neg_lo_q ? -acc_q : acc_q;
      if (is_mul_q) begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end else begin
         fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter_q <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         is_mul_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         if (issue && op_mul) begin
            operand_q <= a_mag;
            acc_q     <= {{WIDTH{1'b0}}, b_mag};
            is_mul_q  <= 1'b1;
            neg_lo_q  <= a_neg ^ b_neg;
            neg_hi_q  <= a_neg ^ b_neg;
            counter_q <= CW'(WIDTH);
         end else if (issue && op_div && b_zero) begin
            // divide-by-zero result is staged unsigned and written straight from FIX
            operand_q <= b;
            acc_q     <= {a, {WIDTH{1'b1}}};
            is_mul_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            counter_q <= '0;
         end else if (issue && op_div) begin
            operand_q <= b_mag;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            is_mul_q  <= 1'b0;
            neg_lo_q  <= a_neg ^ b_neg;
            neg_hi_q  <= a_neg;
            counter_q <= CW'(WIDTH);
         end else if (step_en) begin
            acc_q     <= acc_next;
            counter_q <= counter_q - CW'(1);
         end

         if (hilo_we) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end else begin
            if (mthi_we) hi_q <= a;
            if (mtlo_we) lo_q <= a;
         end
         done_q <= hilo_we;
      end
   end

   assign busy = (state_q != MDU_ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit (MDU) sitting in the execute stage beside the ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers.
- Raises busy so hazard logic stalls any dependent HI/LO access or new MDU op.
- Fed by the decode-stage op encoding (MDU op field issued alongside the ALU op).

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>= 4, even)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  issue op this cycle; honoured only when busy=0
op  in  3  MDU op code (MDU_OP_* constants)
a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort in-flight op (branch/exception squash)
busy  out  1  high while an iterative op is in flight
done  out  1  one-cycle pulse: HI/LO just updated by an iterative op
hi  out  WIDTH  HI register (MFHI source)
lo  out  WIDTH  LO register (MFLO source)

Behaviour:
- Reset, synchronous: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the op; nothing is written.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1 and flush=0:
  - MULT/MULTU: latch magnitudes (signed ops take abs values) and result sign; counter=WIDTH; go to MUL.
  - DIV/DIVU, b!=0: latch magnitudes, quotient sign (sign a XOR sign b) and remainder sign (sign a); go to DIV.
  - DIV/DIVU, b==0: go to FIX with lo=all ones, hi=a (raw). Same for signed and unsigned. done is high in cycle 2 after start.
  - MTHI: hi<=a. MTLO: lo<=a. Both take one cycle, stay IDLE, no busy, no done.
  - Undefined op codes: ignored.
- MUL: radix-2 shift-add into a 2*WIDTH accumulator; counter decrements; at 1, go to FIX.
- DIV: restoring division, one quotient bit per cycle; counter decrements; at 1, go to FIX.
- FIX: apply signs (two's-complement negate where required); write {hi,lo} (product: hi=upper, lo=lower; divide: lo=quotient, hi=remainder); go to IDLE; assert done next cycle.
- Latency: start in cycle 0 -> busy=1 in cycles 1..WIDTH+1 -> hi/lo new and done=1 in cycle WIDTH+2.
- start while busy=1: ignored; no queueing. The pipeline must stall.
- flush=1 in any state: next state IDLE, busy=0, hi/lo unchanged, no done. flush with start in the same cycle: flush wins.
- Signed overflow (most negative / -1): lo=most negative, hi=0; no trap.
- Remainder sign follows the dividend; quotient truncates toward zero.
- busy is registered: busy = (state != IDLE).
- hi/lo are direct register outputs, readable every cycle. Values are stale while busy.

Decomposition:
- Shared header mdu_ops.h, include-guarded like alu_ops.h:
  - MDU_OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - State encodings MDU_ST_IDLE/MUL/DIV/FIX.
- Decode maps SPECIAL funct codes onto these op codes.
- One natural combinational sub-module, muldiv_step (param WIDTH):
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator for one shift-add or one restore step.
  - Instantiated once and shared by MUL and DIV.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF at cycle 0 -> busy cycles 1-33; cycle 34 done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> done in cycle 2, lo=0xFFFFFFFF, hi=0x00000064; busy high only in cycle 1.
- MTHI 0x1234, then MTLO 0x5678 -> next cycle hi=0x1234, lo=0x5678, busy=0 and done=0 throughout. Then MULT with flush at cycle 10 -> busy=0 at cycle 11, hi/lo unchanged, no done pulse.
- Second start (DIVU 9/3) asserted at cycle 5 of an active MULTU 6x7 -> ignored; result hi=0, lo=42. Reissue after busy falls -> lo=3, hi=0.
- rst asserted at cycle 20 of a DIV -> next cycle busy=0, hi=lo=0, done never pulses. WIDTH=8 regression: MULTU 0xFF x 0xFF -> hi=0xFE, lo=0x01 at cycle 10.
